// File: rtl/glyph_scroll_ctrl.sv
// Message sequencer for a column-scanned glyph display: stores host characters, walks them
// through an external sync char ROM and streams column bytes with a blank gap between passes.
// Latency: col_out/col_valid register the ROM byte one cycle after its address; no backpressure.
//
// Ports:
//   clk, rst_n            display clock, synchronous active-low reset
//   wr_en, wr_char        append one character to the message (ignored unless idle or when full)
//   clr                   empty the message and abort any scan
//   run                   level scan enable; a scan stops on a character (or gap) boundary
//   rom_char, rom_col     character ROM address, {char code, column}
//   rom_data              ROM byte, valid the cycle after its address
//   col_out, col_valid    column byte stream (glyph columns, then zero gap columns)
//   frame_start           pulses with column 0 of character 0 of every pass
//   msg_len, full, busy   message length, buffer full, scanner active
module glyph_scroll_ctrl #(
  parameter int WORD_COUNT = 32,
  parameter int CHAR_W     = 6,
  parameter int COLS       = 8,
  parameter int GAP_COLS   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [CHAR_W-1:0]       wr_char,
  input  logic                    clr,
  input  logic                    run,
  output logic [CHAR_W-1:0]       rom_char,
  output logic [$clog2(COLS)-1:0] rom_col,
  input  logic [7:0]              rom_data,
  output logic [7:0]              col_out,
  output logic                    col_valid,
  output logic                    frame_start,
  output logic [5:0]              msg_len,
  output logic                    full,
  output logic                    busy
);

  localparam int COL_W = $clog2(COLS);
  localparam int IDX_W = $clog2(WORD_COUNT);
  localparam int LEN_W = 7;
  localparam int GAP_W = (GAP_COLS > 1) ? $clog2(GAP_COLS) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_COLS > 0) ? GAP_COLS - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WORD_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Message storage; contents are don't-care until written.
  logic [CHAR_W-1:0] msg_buf_q [WORD_COUNT];
  logic              buf_we;
  logic [IDX_W-1:0]  buf_waddr;

  state_e            state_q,   state_d;
  logic [LEN_W-1:0]  msg_len_q, msg_len_d;
  logic [IDX_W-1:0]  ci_q,      ci_d;
  logic [COL_W-1:0]  cc_q,      cc_d;
  logic [GAP_W-1:0]  gap_q,     gap_d;

  // Stage 1 tags the cycle in which the ROM is producing the byte for the address issued
  // the cycle before; stage 2 is the registered output.
  logic              s1_vld_q,  s1_vld_d;
  logic              s1_gap_q,  s1_gap_d;
  logic              s1_fs_q,   s1_fs_d;
  logic [7:0]        col_out_q, col_out_d;
  logic              col_vld_q, col_vld_d;
  logic              fs_q,      fs_d;

  logic              full_w;
  logic              last_char;

  assign full_w    = (msg_len_q == LEN_MAX);
  // ci is the last stored character when ci + 1 == msg_len (no underflow at msg_len 0).
  assign last_char = ((LEN_W'(ci_q) + LEN_W'(1)) == msg_len_q);
  assign buf_waddr = msg_len_q[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    msg_len_d = msg_len_q;
    ci_d      = ci_q;
    cc_d      = cc_q;
    gap_d     = gap_q;
    buf_we    = 1'b0;
    s1_vld_d  = 1'b0;
    s1_gap_d  = 1'b0;
    s1_fs_d   = 1'b0;
    col_vld_d = s1_vld_q;
    fs_d      = s1_fs_q;
    col_out_d = (s1_vld_q && !s1_gap_q) ? rom_data : 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (wr_en && !full_w) begin
          buf_we    = 1'b1;
          msg_len_d = msg_len_q + LEN_W'(1);
        end
        if (run && (msg_len_q != '0)) begin
          state_d = ST_SCAN;
          ci_d    = '0;
          cc_d    = '0;
        end
      end

      ST_SCAN: begin
        s1_vld_d = 1'b1;
        s1_fs_d  = (ci_q == '0) && (cc_q == '0);
        if (cc_q == COL_LAST) begin
          // Character boundary: the only point where run is honoured in SCAN.
          cc_d = '0;
          if (last_char) begin
            ci_d = '0;
            if (!run) begin
              state_d = ST_IDLE;
            end else if (GAP_COLS == 0) begin
              state_d = ST_SCAN;
            end else begin
              state_d = ST_GAP;
              gap_d   = '0;
            end
          end else begin
            ci_d = ci_q + IDX_W'(1);
            if (!run) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          cc_d = cc_q + COL_W'(1);
        end
      end

      ST_GAP: begin
        s1_vld_d = 1'b1;
        s1_gap_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          ci_d    = '0;
          cc_d    = '0;
          state_d = run ? ST_SCAN : ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear flushes the message and the whole column pipeline; a simultaneous write is lost.
    if (clr) begin
      state_d   = ST_IDLE;
      msg_len_d = '0;
      ci_d      = '0;
      cc_d      = '0;
      gap_d     = '0;
      buf_we    = 1'b0;
      s1_vld_d  = 1'b0;
      s1_gap_d  = 1'b0;
      s1_fs_d   = 1'b0;
      col_vld_d = 1'b0;
      fs_d      = 1'b0;
      col_out_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      msg_buf_q[buf_waddr] <= wr_char;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      msg_len_q <= '0;
      ci_q      <= '0;
      cc_q      <= '0;
      gap_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_gap_q  <= 1'b0;
      s1_fs_q   <= 1'b0;
      col_out_q <= 8'h00;
      col_vld_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_len_q <= msg_len_d;
      ci_q      <= ci_d;
      cc_q      <= cc_d;
      gap_q     <= gap_d;
      s1_vld_q  <= s1_vld_d;
      s1_gap_q  <= s1_gap_d;
      s1_fs_q   <= s1_fs_d;
      col_out_q <= col_out_d;
      col_vld_q <= col_vld_d;
      fs_q      <= fs_d;
    end
  end

  // The ROM address is decoded from registered ci/cc; it is held at zero outside SCAN so the
  // never-reset buffer cannot leak onto the bus.
  assign rom_char    = (state_q == ST_SCAN) ? msg_buf_q[ci_q] : '0;
  assign rom_col     = cc_q;
  assign col_out     = col_out_q;
  assign col_valid   = col_vld_q;
  assign frame_start = fs_q;
  assign msg_len     = msg_len_q[5:0];
  assign full        = full_w;
  assign busy        = (state_q != ST_IDLE);

endmodule
